// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
//   Sequential DES round-key generator. Accepts one 64-bit key per job, applies
//   PC-1, then emits the sixteen 48-bit PC-2 subkeys one per handshake:
//   K1..K16 for encrypt, K16..K1 for decrypt. C/D are advanced incrementally,
//   so no subkey storage is needed.
//
// Parameters
//   OUT_REG  0: subkey = PC2(C,D) combinationally
//            1: subkey registered from next-state C/D (same cycle timing)
//
// Optional build macro
//   KEY_PARITY_CHECK_EN  adds parity_err; keys without odd parity in every
//                        byte are consumed but produce no subkeys.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   key_valid/ready    key handshake (ready only while idle)
//   key_in[63:0]       DES key, key_in[63] = FIPS bit 1, parity in 56,48,..,0
//   decrypt            sampled at key accept; 1 = reverse subkey order
//   subkey_valid/ready subkey handshake
//   subkey[47:0]       round key, subkey[47] = FIPS bit 1
//   round_idx[3:0]     sequence index of the presented subkey
//   last               subkey_valid && round_idx == 15
//   parity_err         (macro only) one-cycle pulse on a bad-parity key
// -----------------------------------------------------------------------------
module des_key_schedule #(
   parameter bit OUT_REG = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [63:0] key_in,
   input  logic        decrypt,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [47:0] subkey,
   output logic [3:0]  round_idx,
   output logic        last
`ifdef KEY_PARITY_CHECK_EN
   ,
   output logic        parity_err
`endif
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // FIPS bit numbers (1 = MSB) selected by PC-1 (C then D) and PC-2.
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   // Shift table as a mask: bit s set means SH[s] = 2, clear means 1.
   localparam logic [15:0] SH_TWO = 16'h7EFC;

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
      logic [55:0] cd;
      logic [47:0] r;
      cd = {c, d};
      r  = '0;
      for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
      return r;
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
      return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   state_t      r_state, w_state_nxt;
   logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
   logic        r_dir;
   logic [3:0]  r_idx, w_s, w_sh_idx;
   logic [55:0] w_pc1;
   logic        w_accept, w_load, w_adv, w_final, w_cd_en, w_par_ok, w_two;
   logic        w_unused_par;

   // Parity bits only matter to the optional checker.
   assign w_unused_par = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

`ifdef KEY_PARITY_CHECK_EN
   always_comb begin
      w_par_ok = 1'b1;
      for (int b = 0; b < 8; b++) w_par_ok = w_par_ok & (^key_in[8*b +: 8]);
   end
`else
   assign w_par_ok = 1'b1;
`endif

   assign w_accept = key_valid && (r_state == IDLE);
   assign w_load   = w_accept && w_par_ok;
   assign w_adv    = (r_state == RUN) && subkey_ready;
   assign w_final  = w_adv && (r_idx == 4'd15);
   assign w_pc1    = pc1(key_in);

   // Schedule entry s = round_idx+1; decrypt walks the table backwards from
   // SH[15], i.e. index 16-s, which is just -s modulo 16.
   assign w_s      = r_idx + 4'd1;
   assign w_sh_idx = 4'd0 - w_s;
   assign w_two    = r_dir ? SH_TWO[w_sh_idx] : SH_TWO[w_s];

   always_comb begin
      w_state_nxt  = r_state;
      key_ready    = 1'b0;
      subkey_valid = 1'b0;
      case (r_state)
         IDLE: begin
            key_ready = 1'b1;
            if (w_load) w_state_nxt = RUN;
         end
         RUN: begin
            subkey_valid = 1'b1;
            if (w_final) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Encrypt starts at C1/D1 = rotl1(C0/D0). Decrypt starts at C16/D16, which
   // equals C0/D0 because the total rotation over 16 rounds is 28.
   always_comb begin
      w_c_nxt = r_c;
      w_d_nxt = r_d;
      w_cd_en = 1'b0;
      if (w_load) begin
         w_cd_en = 1'b1;
         w_c_nxt = decrypt ? w_pc1[55:28] : rotl28(w_pc1[55:28], 1'b0);
         w_d_nxt = decrypt ? w_pc1[27:0]  : rotl28(w_pc1[27:0],  1'b0);
      end else if (w_adv && !w_final) begin
         w_cd_en = 1'b1;
         w_c_nxt = r_dir ? rotr28(r_c, w_two) : rotl28(r_c, w_two);
         w_d_nxt = r_dir ? rotr28(r_d, w_two) : rotl28(r_d, w_two);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_c     <= '0;
         r_d     <= '0;
         r_dir   <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_cd_en) begin
            r_c <= w_c_nxt;
            r_d <= w_d_nxt;
         end
         if (w_load) begin
            r_dir <= decrypt;
            r_idx <= '0;
         end else if (w_adv) begin
            r_idx <= w_s;  // wraps 15 -> 0 on the final handshake
         end
      end
   end

`ifdef KEY_PARITY_CHECK_EN
   logic r_parity_err;
   always_ff @(posedge clk) begin
      if (rst) r_parity_err <= 1'b0;
      else     r_parity_err <= w_accept && !w_par_ok;
   end
   assign parity_err = r_parity_err;
`endif

   // The registered variant tracks C/D exactly, so both variants present the
   // same subkey on every cycle.
   generate
      if (OUT_REG) begin : g_oreg
         logic [47:0] r_subkey;
         always_ff @(posedge clk) begin
            if (rst)          r_subkey <= '0;
            else if (w_cd_en) r_subkey <= pc2(w_c_nxt, w_d_nxt);
         end
         assign subkey = r_subkey;
      end else begin : g_comb
         assign subkey = pc2(r_c, r_d);
      end
   endgenerate

   assign round_idx = r_idx;
   assign last      = (r_state == RUN) && (r_idx == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_des_key_schedule
//   Self-checking bench for des_key_schedule. Two instances (OUT_REG=0 and
//   OUT_REG=1) share stimulus and are both checked against a scoreboard filled
//   from a reference model that computes every round key from C0/D0 by its
//   cumulative rotation, plus published known-answer subkeys.
// -----------------------------------------------------------------------------
module tb_des_key_schedule;

   localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
   localparam logic [47:0] K1  = 48'h1B02EFFC7072;
   localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
   localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;
   localparam logic [54:0] RST_OUT = {1'b1, 1'b0, 48'h0, 4'h0, 1'b0};

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic        clk = 1'b0, rst = 1'b1;
   logic        key_valid = 1'b0, decrypt = 1'b0, subkey_ready = 1'b0;
   logic [63:0] key_in = '0;
   logic        kr0, sv0, l0, kr1, sv1, l1;
   logic [47:0] sk0, sk1;
   logic [3:0]  ri0, ri1;
   logic [54:0] o0, o1;
`ifdef KEY_PARITY_CHECK_EN
   logic        pe0, pe1;
`endif

   int          n_cmp = 0, n_bad = 0;
   logic [52:0] sbq [$];          // {subkey, round_idx, last}
   logic [47:0] obs [16];

   always #5 clk = ~clk;

   des_key_schedule #(.OUT_REG(1'b0)) dut0 (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(kr0),
      .key_in(key_in), .decrypt(decrypt), .subkey_valid(sv0),
      .subkey_ready(subkey_ready), .subkey(sk0), .round_idx(ri0), .last(l0)
`ifdef KEY_PARITY_CHECK_EN
      , .parity_err(pe0)
`endif
   );

   des_key_schedule #(.OUT_REG(1'b1)) dut1 (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(kr1),
      .key_in(key_in), .decrypt(decrypt), .subkey_valid(sv1),
      .subkey_ready(subkey_ready), .subkey(sk1), .round_idx(ri1), .last(l1)
`ifdef KEY_PARITY_CHECK_EN
      , .parity_err(pe1)
`endif
   );

   assign o0 = {kr0, sv0, sk0, ri0, l0};
   assign o1 = {kr1, sv1, sk1, ri1, l1};

   // Reference: Kn = PC2(rotl(C0, sum SH[0..n-1]), rotl(D0, ...)).
   function automatic void m_sched(input logic [63:0] k, output logic [47:0] ks [16]);
      logic [55:0] p, cd;
      logic [27:0] c0, d0, c, d;
      int t;
      for (int i = 0; i < 56; i++) p[6'(55 - i)] = k[6'(64 - PC1[i])];
      c0 = p[55:28];
      d0 = p[27:0];
      t  = 0;
      for (int r = 0; r < 16; r++) begin
         t  = t + SH[r];
         c  = (c0 << t) | (c0 >> (28 - t));
         d  = (d0 << t) | (d0 >> (28 - t));
         cd = {c, d};
         for (int j = 0; j < 48; j++) ks[r][6'(47 - j)] = cd[6'(56 - PC2[j])];
      end
   endfunction

   function automatic void push_job(input logic [63:0] k, input logic dec);
      logic [47:0] ks [16];
      m_sched(k, ks);
      for (int i = 0; i < 16; i++)
         sbq.push_back({dec ? ks[15 - i] : ks[i], 4'(i), i == 15});
   endfunction

   function automatic logic [63:0] set_parity(input logic [63:0] k);
      logic [63:0] r;
      r = k;
      for (int b = 0; b < 8; b++) r[8*b] = ~(^r[8*b+1 +: 7]);
      return r;
   endfunction

   // Accept one key with subkey_ready held high and drain all 16 subkeys.
   task automatic run_full(input logic [63:0] k, input logic dec);
      logic [52:0] exp;
      @(posedge clk); #1;
      key_valid = 1'b1; key_in = k; decrypt = dec; subkey_ready = 1'b1;
      push_job(k, dec);
      @(negedge clk);
      n_cmp++;
      if ({kr0, sv0, kr1, sv1} !== 4'b1010) begin
         n_bad++; $display("FAIL accept_ready: got %b want 1010", {kr0, sv0, kr1, sv1});
      end
      @(posedge clk); #1;
      key_valid = 1'b0; key_in = {$urandom, $urandom}; decrypt = ~dec;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (sbq.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL sb_empty: got empty want entry %0d", c);
         end else begin
            exp = sbq.pop_front();
            n_cmp++;
            if (o0 !== {2'b01, exp}) begin
               n_bad++; $display("FAIL seq%0d dut0: got %h want %h", c, o0, {2'b01, exp});
            end
            n_cmp++;
            if (o1 !== {2'b01, exp}) begin
               n_bad++; $display("FAIL seq%0d dut1: got %h want %h", c, o1, {2'b01, exp});
            end
         end
         obs[c] = sk0;
         @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++;
      if ({kr0, sv0, kr1, sv1} !== 4'b1010) begin
         n_bad++; $display("FAIL post_job_idle: got %b want 1010", {kr0, sv0, kr1, sv1});
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (o0 !== RST_OUT) begin n_bad++; $display("FAIL reset dut0: got %h want %h", o0, RST_OUT); end
      n_cmp++;
      if (o1 !== RST_OUT) begin n_bad++; $display("FAIL reset dut1: got %h want %h", o1, RST_OUT); end
`ifdef KEY_PARITY_CHECK_EN
      n_cmp++;
      if ({pe0, pe1} !== 2'b00) begin n_bad++; $display("FAIL reset_perr: got %b want 00", {pe0, pe1}); end
`endif
   endtask

   task automatic test_encrypt;
      run_full(KEY, 1'b0);
      n_cmp++;
      if (obs[0] !== K1) begin n_bad++; $display("FAIL enc_K1: got %h want %h", obs[0], K1); end
      n_cmp++;
      if (obs[1] !== K2) begin n_bad++; $display("FAIL enc_K2: got %h want %h", obs[1], K2); end
      n_cmp++;
      if (obs[15] !== K16) begin n_bad++; $display("FAIL enc_K16: got %h want %h", obs[15], K16); end
   endtask

   task automatic test_decrypt;
      logic [47:0] ks [16];
      m_sched(KEY, ks);
      run_full(KEY, 1'b1);
      n_cmp++;
      if (obs[0] !== K16) begin n_bad++; $display("FAIL dec_first: got %h want %h", obs[0], K16); end
      n_cmp++;
      if (obs[1] !== ks[14]) begin n_bad++; $display("FAIL dec_idx1: got %h want %h", obs[1], ks[14]); end
      n_cmp++;
      if (obs[15] !== K1) begin n_bad++; $display("FAIL dec_last: got %h want %h", obs[15], K1); end
   endtask

   // Random stalls; while stalled the head of the scoreboard must stay on the
   // outputs. Random key_valid pulses during RUN must be ignored.
   task automatic test_backpressure(input logic [63:0] k, input logic dec);
      int got;
      logic [52:0] exp;
      got = 0;
      @(posedge clk); #1;
      key_valid = 1'b1; key_in = k; decrypt = dec;
      push_job(k, dec);
      @(posedge clk); #1;
      key_valid = 1'b0; subkey_ready = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
         @(negedge clk);
         exp = sbq[0];
         n_cmp++;
         if (o0 !== {2'b01, exp}) begin
            n_bad++; $display("FAIL bp%0d dut0: got %h want %h", got, o0, {2'b01, exp});
         end
         n_cmp++;
         if (o1 !== {2'b01, exp}) begin
            n_bad++; $display("FAIL bp%0d dut1: got %h want %h", got, o1, {2'b01, exp});
         end
         if (subkey_ready) begin
            void'(sbq.pop_front());
            got++;
         end
         @(posedge clk); #1;
         if (got < 16) begin
            subkey_ready = 1'($urandom_range(0, 1));
            key_valid    = ($urandom_range(0, 3) == 0);
            key_in       = {$urandom, $urandom};
            decrypt      = 1'($urandom_range(0, 1));
         end else begin
            key_valid    = 1'b0;
            subkey_ready = 1'b1;
         end
      end
      n_cmp++;
      if (got != 16) begin n_bad++; $display("FAIL bp_timeout: got %0d want 16", got); end
      @(negedge clk);
      n_cmp++;
      if ({kr0, sv0, kr1, sv1} !== 4'b1010) begin
         n_bad++; $display("FAIL bp_idle: got %b want 1010", {kr0, sv0, kr1, sv1});
      end
      sbq.delete();
   endtask

   task automatic test_reset_mid;
      bit hit;
      hit = 1'b0;
      @(posedge clk); #1;
      key_valid = 1'b1; key_in = KEY; decrypt = 1'b0; subkey_ready = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         if (ri0 == 4'd7 && sv0) hit = 1'b1;
         else begin @(posedge clk); #1; end
      end
      n_cmp++;
      if (!hit) begin n_bad++; $display("FAIL mid_idx7: got %0d want 7", ri0); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (o0 !== RST_OUT) begin n_bad++; $display("FAIL mid_rst dut0: got %h want %h", o0, RST_OUT); end
      n_cmp++;
      if (o1 !== RST_OUT) begin n_bad++; $display("FAIL mid_rst dut1: got %h want %h", o1, RST_OUT); end
      @(negedge clk);
      n_cmp++;
      if ({sv0, sv1} !== 2'b00) begin n_bad++; $display("FAIL mid_quiet: got %b want 00", {sv0, sv1}); end
      sbq.delete();
      run_full(KEY, 1'b0);
      n_cmp++;
      if (obs[0] !== K1) begin n_bad++; $display("FAIL mid_fresh_K1: got %h want %h", obs[0], K1); end
   endtask

   task automatic test_parity;
`ifdef KEY_PARITY_CHECK_EN
      @(posedge clk); #1;
      key_valid = 1'b1; key_in = 64'h133457799BBCDFF0; decrypt = 1'b0; subkey_ready = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({pe0, sv0, kr0, pe1, sv1, kr1} !== 6'b101101) begin
         n_bad++; $display("FAIL par_pulse: got %b want 101101", {pe0, sv0, kr0, pe1, sv1, kr1});
      end
      @(negedge clk);
      n_cmp++;
      if ({pe0, sv0, kr0, pe1, sv1, kr1} !== 6'b001001) begin
         n_bad++; $display("FAIL par_one_cycle: got %b want 001001", {pe0, sv0, kr0, pe1, sv1, kr1});
      end
      run_full(KEY, 1'b0);
      n_cmp++;
      if ({pe0, pe1} !== 2'b00) begin n_bad++; $display("FAIL par_good: got %b want 00", {pe0, pe1}); end
      n_cmp++;
      if (obs[0] !== K1) begin n_bad++; $display("FAIL par_good_K1: got %h want %h", obs[0], K1); end
`else
      run_full(64'h133457799BBCDFF0, 1'b0);
      n_cmp++;
      if (obs[0] !== K1) begin n_bad++; $display("FAIL noparity_K1: got %h want %h", obs[0], K1); end
      n_cmp++;
      if (obs[15] !== K16) begin n_bad++; $display("FAIL noparity_K16: got %h want %h", obs[15], K16); end
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_encrypt;
      test_decrypt;
      test_backpressure(KEY, 1'b0);
      test_backpressure(set_parity({$urandom, $urandom}), 1'b1);
      test_reset_mid;
      test_parity;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
